// File: rtl/shift_reg_univ.sv
// Universal shift register: hold / shift right / shift left / parallel load with clock enable,
// complementary and serial outputs, saturating shift counter. Define SHIFT_REG_ROTATE_EN to rotate.
module shift_reg_univ #(
  parameter int unsigned      WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  localparam int unsigned     CW          = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             sin_r,
  input  logic             sin_l,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_bar,
  output logic             sout_r,
  output logic             sout_l,
  output logic [CW-1:0]    shift_cnt,
  output logic             drained
);

  typedef enum logic [1:0] {
    ModeHold  = 2'b00,
    ModeRight = 2'b01,
    ModeLeft  = 2'b10,
    ModeLoad  = 2'b11
  } mode_e;

  localparam logic [CW-1:0] CntMax = CW'(WIDTH);

  logic [WIDTH-1:0] r_q;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] w_q_next;
  logic [CW-1:0]    w_cnt_next;
  logic [CW-1:0]    w_cnt_inc;
  logic [WIDTH-1:0] w_shr;
  logic [WIDTH-1:0] w_shl;
  logic             w_in_r;
  logic             w_in_l;

`ifdef SHIFT_REG_ROTATE_EN
  logic w_unused_sin;
  assign w_unused_sin = sin_r ^ sin_l;
  assign w_in_r       = r_q[0];
  assign w_in_l       = r_q[WIDTH-1];
`else
  assign w_in_r = sin_r;
  assign w_in_l = sin_l;
`endif

  // Bitwise build keeps WIDTH=1 legal (no reversed part-selects).
  always_comb begin
    w_shr = '0;
    w_shl = '0;
    for (int i = 0; i < int'(WIDTH) - 1; i++) begin
      w_shr[i]   = r_q[i+1];
      w_shl[i+1] = r_q[i];
    end
    w_shr[WIDTH-1] = w_in_r;
    w_shl[0]       = w_in_l;
  end

  assign w_cnt_inc = (r_cnt == CntMax) ? r_cnt : r_cnt + CW'(1);

  always_comb begin
    w_q_next   = r_q;
    w_cnt_next = r_cnt;
    case (mode_e'(mode))
      ModeRight: begin
        w_q_next   = w_shr;
        w_cnt_next = w_cnt_inc;
      end
      ModeLeft: begin
        w_q_next   = w_shl;
        w_cnt_next = w_cnt_inc;
      end
      ModeLoad: begin
        w_q_next   = d;
        w_cnt_next = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q   <= RESET_VALUE;
      r_cnt <= '0;
    end else if (en) begin
      r_q   <= w_q_next;
      r_cnt <= w_cnt_next;
    end
  end

  assign q         = r_q;
  assign q_bar     = ~r_q;
  assign sout_r    = r_q[0];
  assign sout_l    = r_q[WIDTH-1];
  assign shift_cnt = r_cnt;
  assign drained   = (r_cnt == CntMax);

endmodule

// File: tb/tb_shift_reg_univ.sv
// Self-checking bench for shift_reg_univ: directed scenarios plus randomized traffic
// checked against an arithmetic reference model (8-bit and 1-bit instances).
module tb_shift_reg_univ;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic [1:0] mode = 2'b00;
  logic       sin_r = 1'b0;
  logic       sin_l = 1'b0;
  logic [7:0] d = 8'h00;
  logic [7:0] q, q_bar;
  logic       sout_r, sout_l, drained;
  logic [3:0] shift_cnt;

  logic       en1 = 1'b0;
  logic [1:0] mode1 = 2'b00;
  logic       sin_r1 = 1'b0;
  logic       sin_l1 = 1'b0;
  logic [0:0] d1 = 1'b0;
  logic [0:0] q1, q_bar1, cnt1;
  logic       sout_r1, sout_l1, drained1;

  int n_chk = 0;
  int n_err = 0;
  int m_q   = 0;
  int m_cnt = 0;

  always #5 clk = ~clk;

  shift_reg_univ #(.WIDTH(8)) u_dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sin_r(sin_r), .sin_l(sin_l), .d(d),
    .q(q), .q_bar(q_bar), .sout_r(sout_r), .sout_l(sout_l), .shift_cnt(shift_cnt),
    .drained(drained)
  );

  shift_reg_univ #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst(rst), .en(en1), .mode(mode1), .sin_r(sin_r1), .sin_l(sin_l1), .d(d1),
    .q(q1), .q_bar(q_bar1), .sout_r(sout_r1), .sout_l(sout_l1), .shift_cnt(cnt1),
    .drained(drained1)
  );

  // Reference: register as an integer, shifts as arithmetic, count saturating at 8.
  task automatic drive(input logic e, input logic [1:0] m, input logic sr, input logic sl,
                       input logic [7:0] dd);
    int in_bit;
    en = e; mode = m; sin_r = sr; sin_l = sl; d = dd;
    if (e) begin
      if (m == 2'd1) begin
`ifdef SHIFT_REG_ROTATE_EN
        in_bit = m_q % 2;
`else
        in_bit = int'(sr);
`endif
        m_q   = (m_q / 2) + in_bit * 128;
        m_cnt = (m_cnt < 8) ? m_cnt + 1 : 8;
      end else if (m == 2'd2) begin
`ifdef SHIFT_REG_ROTATE_EN
        in_bit = m_q / 128;
`else
        in_bit = int'(sl);
`endif
        m_q   = (m_q * 2 + in_bit) % 256;
        m_cnt = (m_cnt < 8) ? m_cnt + 1 : 8;
      end else if (m == 2'd3) begin
        m_q   = int'(dd);
        m_cnt = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    #1;
    m_q = 0; m_cnt = 0;
    n_chk++; if (q !== 8'h00) begin n_err++; $display("FAIL reset_q got=%h want=00", q); end
    n_chk++; if (q_bar !== 8'hFF) begin n_err++; $display("FAIL reset_qbar got=%h want=FF", q_bar); end
    n_chk++; if (shift_cnt !== 4'd0) begin n_err++; $display("FAIL reset_cnt got=%0d want=0", shift_cnt); end
    n_chk++; if (drained !== 1'b0) begin n_err++; $display("FAIL reset_drained got=%b want=0", drained); end
    rst = 1'b0;
    drive(1'b1, 2'b00, 1'b1, 1'b1, 8'hFF);
    n_chk++; if (q !== 8'h00 || shift_cnt !== 4'd0) begin
      n_err++; $display("FAIL reset_hold got=%h/%0d want=00/0", q, shift_cnt);
    end
  endtask

  task automatic test_load_hold();
    drive(1'b1, 2'b11, 1'b0, 1'b0, 8'hA5);
    n_chk++; if (q !== 8'hA5) begin n_err++; $display("FAIL load_q got=%h want=A5", q); end
    n_chk++; if (q_bar !== 8'h5A) begin n_err++; $display("FAIL load_qbar got=%h want=5A", q_bar); end
    n_chk++; if (shift_cnt !== 4'd0) begin n_err++; $display("FAIL load_cnt got=%0d want=0", shift_cnt); end
    for (int i = 0; i < 3; i++) drive(1'b0, 2'b01, 1'b1, 1'b1, 8'h3C);
    n_chk++; if (q !== 8'hA5 || shift_cnt !== 4'd0) begin
      n_err++; $display("FAIL en0_hold got=%h/%0d want=A5/0", q, shift_cnt);
    end
  endtask

  task automatic test_shift_right_drain();
    logic [7:0] exp_seq;
    exp_seq = 8'b1010_0101; // sout_r order, first bit in exp_seq[7]
    drive(1'b1, 2'b11, 1'b0, 1'b0, 8'hA5);
    for (int i = 0; i < 8; i++) begin
      n_chk++; if (sout_r !== exp_seq[7-i]) begin
        n_err++; $display("FAIL sout_r_seq[%0d] got=%b want=%b", i, sout_r, exp_seq[7-i]);
      end
      drive(1'b1, 2'b01, 1'b0, 1'b0, 8'h00);
    end
`ifdef SHIFT_REG_ROTATE_EN
    n_chk++; if (q !== 8'hA5) begin n_err++; $display("FAIL drain_q got=%h want=A5", q); end
`else
    n_chk++; if (q !== 8'h00) begin n_err++; $display("FAIL drain_q got=%h want=00", q); end
`endif
    n_chk++; if (shift_cnt !== 4'd8 || drained !== 1'b1) begin
      n_err++; $display("FAIL drain_cnt got=%0d/%b want=8/1", shift_cnt, drained);
    end
    drive(1'b1, 2'b01, 1'b1, 1'b0, 8'h00);
    n_chk++; if (shift_cnt !== 4'd8 || drained !== 1'b1 || q !== 8'(m_q)) begin
      n_err++; $display("FAIL saturate got=%h/%0d want=%h/8", q, shift_cnt, 8'(m_q));
    end
  endtask

  task automatic test_shift_left_fill();
    logic [3:0] bits;
    bits = 4'b1101;
    drive(1'b1, 2'b11, 1'b0, 1'b0, 8'h00);
    for (int i = 3; i >= 0; i--) drive(1'b1, 2'b10, 1'b0, bits[i], 8'h00);
`ifndef SHIFT_REG_ROTATE_EN
    n_chk++; if (q !== 8'h0D) begin n_err++; $display("FAIL fill_q got=%h want=0D", q); end
`endif
    n_chk++; if (q !== 8'(m_q)) begin n_err++; $display("FAIL fill_model got=%h want=%h", q, 8'(m_q)); end
    n_chk++; if (shift_cnt !== 4'd4 || drained !== 1'b0) begin
      n_err++; $display("FAIL fill_cnt got=%0d/%b want=4/0", shift_cnt, drained);
    end
    drive(1'b1, 2'b00, 1'b0, 1'b0, 8'h00);
    n_chk++; if (shift_cnt !== 4'd4) begin n_err++; $display("FAIL hold_keeps_cnt got=%0d want=4", shift_cnt); end
    drive(1'b1, 2'b11, 1'b0, 1'b0, 8'hFF);
    n_chk++; if (q !== 8'hFF || shift_cnt !== 4'd0 || sout_l !== 1'b1) begin
      n_err++; $display("FAIL reload got=%h/%0d want=FF/0", q, shift_cnt);
    end
  endtask

`ifdef SHIFT_REG_ROTATE_EN
  task automatic test_rotate();
    drive(1'b1, 2'b11, 1'b0, 1'b0, 8'h81);
    drive(1'b1, 2'b01, 1'b0, 1'b0, 8'h00);
    n_chk++; if (q !== 8'hC0) begin n_err++; $display("FAIL rot_first got=%h want=C0", q); end
    for (int i = 0; i < 7; i++) drive(1'b1, 2'b01, 1'b0, 1'b0, 8'h00);
    n_chk++; if (q !== 8'h81 || drained !== 1'b1) begin
      n_err++; $display("FAIL rot_full got=%h/%b want=81/1", q, drained);
    end
  endtask
`endif

  task automatic test_reset_mid();
    drive(1'b1, 2'b11, 1'b0, 1'b0, 8'h5A);
    drive(1'b1, 2'b10, 1'b0, 1'b1, 8'h00);
    en = 1'b1; mode = 2'b01;
    #2 rst = 1'b1;
    #1;
    m_q = 0; m_cnt = 0;
    n_chk++; if (q !== 8'h00 || q_bar !== 8'hFF || shift_cnt !== 4'd0 || drained !== 1'b0) begin
      n_err++; $display("FAIL mid_reset got=%h/%h/%0d want=00/FF/0", q, q_bar, shift_cnt);
    end
    #1 rst = 1'b0;
  endtask

  task automatic test_random();
    int r;
    logic [1:0] m;
    for (int it = 0; it < 400; it++) begin
      r = $urandom_range(0, 7);
      m = (r == 0) ? 2'd3 : (r < 2) ? 2'd0 : (r < 5) ? 2'd1 : 2'd2;
      drive(($urandom_range(0, 4) != 0), m, 1'($urandom), 1'($urandom), 8'($urandom));
      n_chk++; if (q !== 8'(m_q) || q_bar !== ~8'(m_q)) begin
        n_err++; $display("FAIL rand_q[%0d] got=%h/%h want=%h", it, q, q_bar, 8'(m_q));
      end
      n_chk++; if (sout_r !== 1'(m_q % 2) || sout_l !== 1'(m_q / 128)) begin
        n_err++; $display("FAIL rand_sout[%0d] got=%b%b want q=%h", it, sout_l, sout_r, 8'(m_q));
      end
      n_chk++; if (shift_cnt !== 4'(m_cnt) || drained !== (m_cnt == 8)) begin
        n_err++; $display("FAIL rand_cnt[%0d] got=%0d/%b want=%0d", it, shift_cnt, drained, m_cnt);
      end
    end
  endtask

  task automatic test_width1();
    logic exp_q;
`ifdef SHIFT_REG_ROTATE_EN
    exp_q = 1'b0;
`else
    exp_q = 1'b1;
`endif
    n_chk++; if (q1 !== 1'b0 || cnt1 !== 1'b0 || drained1 !== 1'b0) begin
      n_err++; $display("FAIL w1_init got=%b/%b want=0/0", q1, cnt1);
    end
    en1 = 1'b1; mode1 = 2'b10; sin_l1 = 1'b1; sin_r1 = 1'b0;
    @(posedge clk); #1;
    n_chk++; if (q1 !== exp_q || sout_l1 !== exp_q || sout_r1 !== exp_q || q_bar1 !== ~exp_q) begin
      n_err++; $display("FAIL w1_shl got=%b/%b/%b want=%b", q1, sout_l1, sout_r1, exp_q);
    end
    n_chk++; if (drained1 !== 1'b1 || cnt1 !== 1'b1) begin
      n_err++; $display("FAIL w1_drained got=%b want=1", drained1);
    end
    mode1 = 2'b01; sin_r1 = ~exp_q;
    @(posedge clk); #1;
`ifdef SHIFT_REG_ROTATE_EN
    n_chk++; if (q1 !== exp_q || drained1 !== 1'b1) begin
`else
    n_chk++; if (q1 !== ~exp_q || drained1 !== 1'b1) begin
`endif
      n_err++; $display("FAIL w1_shr got=%b/%b", q1, drained1);
    end
    en1 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_width1();
    test_load_hold();
    test_shift_right_drain();
    test_shift_left_fill();
`ifdef SHIFT_REG_ROTATE_EN
    test_rotate();
`endif
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/shift_reg_univ.md
Name: shift_reg_univ

Overview:
Parametrised universal shift register: WIDTH-bit edge-triggered register with hold, shift-right, shift-left and parallel-load modes, plus a synchronous clock enable.
- Provides complementary outputs (q, q_bar), serial outputs at both ends, and a saturating shift counter with a drained flag for serializer use.
- Next-generation storage element for the datapath catalog; used as a serializer/deserializer, delay line, or loadable register.

Parameters:
WIDTH, 8, register width in bits; legal range >= 1.
RESET_VALUE, {WIDTH{1'b0}}, value of q on reset.
CW (localparam), $clog2(WIDTH+1), width of shift_cnt.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  asynchronous, active-high reset.
en  input  1  clock enable; 0 = hold all state.
mode  input  2  00 hold, 01 shift right (toward LSB), 10 shift left (toward MSB), 11 parallel load.
sin_r  input  1  serial input entering q[WIDTH-1] on shift right.
sin_l  input  1  serial input entering q[0] on shift left.
d  input  WIDTH  parallel load data.
q  output  WIDTH  register contents.
q_bar  output  WIDTH  bitwise complement of q.
sout_r  output  1  q[0]; the bit leaving on the next shift right.
sout_l  output  1  q[WIDTH-1]; the bit leaving on the next shift left.
shift_cnt  output  CW  shifts since last load or reset, saturating at WIDTH.
drained  output  1  1 when shift_cnt == WIDTH.

Behaviour:
- Reset (rst=1, asynchronous assert, takes effect without a clock edge):
  - q = RESET_VALUE; q_bar = ~RESET_VALUE; shift_cnt = 0; drained = 0.
  - Reset overrides en and mode. Deassertion is sampled at the next rising clk edge; the first update occurs on the first edge with rst=0.
- Rising clk edge with rst=0 and en=1:
  - 00 hold: q and shift_cnt unchanged.
  - 01 shift right: q <= {sin_r, q[WIDTH-1:1]}; shift_cnt <= min(shift_cnt+1, WIDTH).
  - 10 shift left: q <= {q[WIDTH-2:0], sin_l}; shift_cnt <= min(shift_cnt+1, WIDTH).
  - 11 load: q <= d; shift_cnt <= 0.
- en=0: all state held regardless of mode, d, or serial inputs.
- Latency: q reflects any operation one edge after it is sampled.
- Derived outputs are combinational from registered state, so they have no extra latency and glitch only with q:
  - q_bar = ~q
  - sout_r = q[0]
  - sout_l = q[WIDTH-1]
  - drained = (shift_cnt == WIDTH)
- WIDTH=1 boundary: shift right gives q <= sin_r; shift left gives q <= sin_l; sout_r == sout_l == q[0]; drained asserts after 1 shift.
- Saturation: further shifts at shift_cnt == WIDTH keep the count at WIDTH and drained=1. Data continues shifting normally.
- Only a load or a reset clears shift_cnt. Hold does not clear it.
- Mode changes take effect on the next edge; there is no extra state and no mode-change penalty.
- Reset asserted mid-shift sequence: immediate return to reset values; the in-flight operation is discarded.

Optional Feature:
SHIFT_REG_ROTATE_EN
- Defined:
  - Shift right feeds q[0] into q[WIDTH-1] and ignores sin_r.
  - Shift left feeds q[WIDTH-1] into q[0] and ignores sin_l.
  - shift_cnt and drained behave identically to the non-rotate build.
- Undefined: serial inputs are used as described under Behaviour.
- Port list is identical in both builds. sin_r/sin_l remain present but unused when rotate is compiled in.

Test Plan:
- Reset: assert rst mid-cycle with no clk edge -> q=8'h00, q_bar=8'hFF, shift_cnt=0, drained=0 immediately. Deassert, then edge with en=1/mode=00 -> unchanged.
- Load then hold: d=8'hA5, mode=11, 1 edge -> q=8'hA5, q_bar=8'h5A, shift_cnt=0. Then en=0 with mode=01 for 3 edges -> q stays 8'hA5.
- Shift right drain: load 8'hA5; sin_r=0, mode=01 for 8 edges -> sout_r sequence 1,0,1,0,0,1,0,1; q=8'h00; shift_cnt=8; drained=1. 9th shift -> shift_cnt stays 8.
- Shift left fill: load 8'h00; mode=10, sin_l sequence 1,1,0,1 -> q=8'h0D, shift_cnt=4, drained=0. Then load 8'hFF -> shift_cnt=0.
- Rotate build (SHIFT_REG_ROTATE_EN): load 8'h81, sin_r=0, mode=01 for 1 edge -> q=8'hC0. After 8 total right shifts -> q=8'h81, drained=1.
- WIDTH=1 instance: sin_l=1, mode=10, 1 edge -> q=1, sout_l=sout_r=1, drained=1.
